spi_sram_slave_ctrl: RTL

- Parametrised SPI slave front-end with an embedded SRAM array. Successor to the fixed 8-bit command/address/data SPI-SRAM datapath.
- Accepts an 8-bit command, an AW-bit address and DW-bit data words over sdi/sdo.
- Adds three address modes: byte, page burst and sequential burst, plus a readable/writable mode/status register.
- Sits between the off-chip SPI master pins and the on-chip storage, replacing the separate counter, buffer and controller instances with one block.

---
 rtl/spi_sram_slave_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_sram_slave_ctrl.sv
// SPI slave front-end with an embedded SRAM. It takes a command, then an address,
// then data words, and supports byte, page-burst and sequential-burst addressing plus a mode/status register.
module spi_sram_slave_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 256,
  parameter int PAGE  = 32
) (
  input  logic       sck,
  input  logic       rst,
  input  logic       ss,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_en,
  output logic [1:0] mode,
  output logic       err
);

  localparam int MAXW = (AW > DW) ? ((AW > 8) ? AW : 8) : ((DW > 8) ? DW : 8);
  localparam int SW   = MAXW - 1;
  localparam int TW   = (DW > 8) ? DW : 8;
  localparam int CW   = $clog2(MAXW);
  localparam logic [AW-1:0] PMASK = AW'(PAGE - 1);
  localparam logic [1:0] M_BYTE = 2'b00;
  localparam logic [1:0] M_PAGE = 2'b01;
  localparam logic [1:0] M_SEQ  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_RDSR, S_WRSR, S_HOLD
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [SW-1:0]   r_shift;
  logic [TW-1:0]   r_tx;
  logic            r_sdo_en;
  logic [AW-1:0]   r_addr;
  logic            r_rd, w_rd_nxt;
  logic [1:0]      r_mode;
  logic            r_err;
  logic [DW-1:0]   r_mem [DEPTH];

  logic [7:0]      w_cmd_byte;
  logic [7:0]      w_status;
  logic [AW-1:0]   w_addr_in;
  logic [AW-1:0]   w_addr_next;
  logic [AW-1:0]   w_rd_addr;
  logic [DW-1:0]   w_rd_word;
  logic [DW-1:0]   w_wr_word;
  logic            w_last8, w_last_addr, w_last_word;
  logic            w_tx_clr, w_tx_ld_mem, w_tx_ld_sr, w_tx_shift;
  logic            w_mem_we, w_addr_ld, w_addr_adv;
  logic            w_err_set, w_err_clr, w_mode_ld;

  function automatic logic [AW-1:0] f_mod(input logic [AW-1:0] a);
    if (DEPTH == (1 << AW)) return a;
    else                    return AW'(32'(a) % DEPTH);
  endfunction

  // The bit just sampled completes the field, so every decode uses {shift, sdi}.
  assign w_cmd_byte  = {r_shift[6:0], sdi};
  assign w_addr_in   = f_mod({r_shift[AW-2:0], sdi});
  assign w_wr_word   = {r_shift[DW-2:0], sdi};
  assign w_status    = {r_mode, 5'b0, r_err};
  assign w_last8     = (r_cnt == CW'(7));
  assign w_last_addr = (r_cnt == CW'(AW - 1));
  assign w_last_word = (r_cnt == CW'(DW - 1));
  assign w_rd_word   = r_mem[w_rd_addr];

  always_comb begin
    w_addr_next = r_addr;
    case (r_mode)
      M_SEQ:   w_addr_next = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
      M_PAGE:  w_addr_next = (r_addr & ~PMASK) | ((r_addr + 1'b1) & PMASK);
      default: w_addr_next = r_addr;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_nxt    = r_rd;
    w_rd_addr   = w_addr_next;
    w_tx_clr    = 1'b0;
    w_tx_ld_mem = 1'b0;
    w_tx_ld_sr  = 1'b0;
    w_tx_shift  = 1'b0;
    w_mem_we    = 1'b0;
    w_addr_ld   = 1'b0;
    w_addr_adv  = 1'b0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    w_mode_ld   = 1'b0;
    if (ss) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_tx_clr    = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_CMD;
          w_cnt_nxt   = CW'(1);
        end
        S_CMD: begin
          if (w_last8) begin
            w_cnt_nxt = '0;
            w_err_clr = 1'b1;
            case (w_cmd_byte)
              8'h03: begin w_state_nxt = S_ADDR; w_rd_nxt = 1'b1; end
              8'h02: begin w_state_nxt = S_ADDR; w_rd_nxt = 1'b0; end
              // Status is captured before the decode-time err clear takes effect.
              8'h05: begin w_state_nxt = S_RDSR; w_tx_ld_sr = 1'b1; end
              8'h01: w_state_nxt = S_WRSR;
              default: begin
                w_state_nxt = S_HOLD;
                w_err_clr   = 1'b0;
                w_err_set   = 1'b1;
              end
            endcase
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_ADDR: begin
          if (w_last_addr) begin
            w_cnt_nxt = '0;
            w_addr_ld = 1'b1;
            if (r_rd) begin
              w_rd_addr   = w_addr_in;
              w_tx_ld_mem = 1'b1;
              w_state_nxt = S_RDATA;
            end else begin
              w_state_nxt = S_WDATA;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_RDATA: begin
          if (w_last_word) begin
            w_cnt_nxt = '0;
            if (r_mode == M_BYTE) begin
              w_state_nxt = S_HOLD;
              w_tx_clr    = 1'b1;
            end else begin
              w_addr_adv  = 1'b1;
              w_tx_ld_mem = 1'b1;
            end
          end else begin
            w_cnt_nxt  = r_cnt + 1'b1;
            w_tx_shift = 1'b1;
          end
        end
        S_WDATA: begin
          if (w_last_word) begin
            w_cnt_nxt = '0;
            w_mem_we  = 1'b1;
            if (r_mode == M_BYTE) w_state_nxt = S_HOLD;
            else                  w_addr_adv  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_RDSR: begin
          if (w_last8) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_HOLD;
            w_tx_clr    = 1'b1;
          end else begin
            w_cnt_nxt  = r_cnt + 1'b1;
            w_tx_shift = 1'b1;
          end
        end
        S_WRSR: begin
          if (w_last8) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_HOLD;
            if (w_cmd_byte[7:6] == 2'b11) w_err_set = 1'b1;
            else                          w_mode_ld = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_HOLD:  w_state_nxt = S_HOLD;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_tx     <= '0;
      r_sdo_en <= 1'b0;
      r_addr   <= '0;
      r_rd     <= 1'b0;
      r_mode   <= M_BYTE;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rd    <= w_rd_nxt;
      r_shift <= ss ? '0 : {r_shift[SW-2:0], sdi};
      // The tx shifter is left-aligned so sdo is always its MSB flop.
      if (w_tx_clr) begin
        r_tx     <= '0;
        r_sdo_en <= 1'b0;
      end else if (w_tx_ld_mem) begin
        r_tx     <= TW'(w_rd_word) << (TW - DW);
        r_sdo_en <= 1'b1;
      end else if (w_tx_ld_sr) begin
        r_tx     <= TW'(w_status) << (TW - 8);
        r_sdo_en <= 1'b1;
      end else if (w_tx_shift) begin
        r_tx <= r_tx << 1;
      end
      if (w_addr_ld)       r_addr <= w_addr_in;
      else if (w_addr_adv) r_addr <= w_addr_next;
      if (w_mode_ld) r_mode <= w_cmd_byte[7:6];
      if (w_err_set)      r_err <= 1'b1;
      else if (w_err_clr) r_err <= 1'b0;
    end
  end

  // Storage has no reset; contents survive rst.
  always_ff @(posedge sck) begin
    if (w_mem_we) r_mem[r_addr] <= w_wr_word;
  end

  assign sdo    = r_tx[TW-1];
  assign sdo_en = r_sdo_en;
  assign mode   = r_mode;
  assign err    = r_err;

endmodule
